// File: rtl/prbs_bert_ctrl.sv
// prbs_bert_ctrl: PRBS7/15/31 bit-error-rate test sequencer with a self-synchronising receive checker
// Ports: clk; rst_n (synchronous, active-high reset); start/stop control pulses; poly_sel (00=7, 01=15, 1x=31);
//   burst_len (0 = continuous until stop); inject (live only when PRBS_ERR_INJECT_EN is defined);
//   tx_bit/tx_valid generator output; rx_bit/rx_valid looped-back input; busy; done; locked;
//   err_cnt/err_sat saturating error count.
module prbs_bert_ctrl #(
  parameter logic [31:0] SEED = 32'h0000_0001,
  parameter int ERR_W = 16,
  parameter int LOCK_RUN = 16,
  parameter int DRAIN_CYC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       poly_sel,
  input  logic [15:0]      burst_len,
  input  logic             inject,
  output logic             tx_bit,
  output logic             tx_valid,
  input  logic             rx_bit,
  input  logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_sat
);
  localparam int MW = $clog2(LOCK_RUN + 1);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam logic [MW-1:0] LOCK_V = MW'(LOCK_RUN);
  localparam logic [DW-1:0] DRAIN_V = DW'(DRAIN_CYC);
  typedef enum logic [1:0] {S_IDLE, S_SEED, S_RUN, S_DRAIN} state_t;
  state_t state, nxt;
  logic [1:0] sel;
  logic [15:0] len, sent;
  logic [30:0] gen, chk, mask;
  logic [4:0] order, sync;
  logic [MW-1:0] match, match_nx;
  logic [2:0] miss, miss_nx;
  logic [DW-1:0] dcnt;
  logic [ERR_W-1:0] err_nx;
  logic fb, mis, chk_en, inj;
  function automatic logic [30:0] mask_of(input logic [1:0] p);
    return p == 2'd0 ? 31'h7f : p == 2'd1 ? 31'h7fff : 31'h7fff_ffff;
  endfunction
  // An all-zero LFSR would lock up, so a seed that masks to zero becomes 1.
  function automatic logic [30:0] seed_of(input logic [1:0] p);
    return (SEED[30:0] & mask_of(p)) == '0 ? 31'd1 : SEED[30:0] & mask_of(p);
  endfunction
  function automatic logic tap(input logic [30:0] s, input logic [1:0] p);
    return p == 2'd0 ? s[6] ^ s[5] : p == 2'd1 ? s[14] ^ s[13] : s[30] ^ s[27];
  endfunction
`ifdef PRBS_ERR_INJECT_EN
  assign inj = inject;
`else
  logic unused_inject;
  assign unused_inject = inject;
  assign inj = 1'b0;
`endif
  always_comb begin
    mask = mask_of(sel);
    order = sel == 2'd0 ? 5'd7 : sel == 2'd1 ? 5'd15 : 5'd31;
    fb = tap(gen, sel);
    mis = rx_bit ^ tap(chk, sel);
    chk_en = rx_valid && (state == S_RUN || state == S_DRAIN);
    err_nx = &err_cnt ? err_cnt : err_cnt + ERR_W'(1);
    match_nx = match == LOCK_V ? match : match + MW'(1);
    miss_nx = miss == 3'd4 ? miss : miss + 3'd1;
    nxt = state;
    case (state)
      S_IDLE:  nxt = start ? S_SEED : S_IDLE;
      S_SEED:  nxt = S_RUN;
      S_RUN:   nxt = stop || (len != '0 && sent + 16'd1 == len) ? S_DRAIN : S_RUN;
      default: nxt = dcnt == DRAIN_V ? S_IDLE : S_DRAIN;
    endcase
  end
  always_ff @(posedge clk) state <= rst_n ? S_IDLE : nxt;
  always_ff @(posedge clk) begin
    if (rst_n) begin
      gen <= seed_of(2'd0);
      chk <= seed_of(2'd0);
      sel <= '0;
      len <= '0;
      sent <= '0;
      sync <= '0;
      match <= '0;
      miss <= '0;
      dcnt <= '0;
      tx_bit <= 1'b0;
      tx_valid <= 1'b0;
      done <= 1'b0;
      locked <= 1'b0;
      err_cnt <= '0;
    end else begin
      tx_valid <= state == S_RUN;
      tx_bit <= state == S_RUN && (fb ^ inj);
      done <= state == S_DRAIN && dcnt == DRAIN_V;
      dcnt <= state == S_DRAIN ? dcnt + DW'(1) : '0;
      if (state == S_IDLE && start) begin
        sel <= poly_sel;
        len <= burst_len;
        sent <= '0;
        sync <= '0;
        match <= '0;
        miss <= '0;
        locked <= 1'b0;
        err_cnt <= '0;
      end
      if (state == S_SEED) gen <= seed_of(sel);
      if (state == S_RUN) begin
        gen <= {gen[29:0], fb} & mask;
        sent <= sent + 16'd1;
      end
      // The checker shifts in received bits, never its own prediction, so it re-aligns by itself.
      if (chk_en) begin
        chk <= {chk[29:0], rx_bit} & mask;
        if (sync != order) sync <= sync + 5'd1;
        else if (mis) begin
          err_cnt <= err_nx;
          match <= '0;
          miss <= miss_nx;
          if (miss_nx == 3'd4) locked <= 1'b0;
        end else begin
          match <= match_nx;
          miss <= '0;
          if (match_nx == LOCK_V) locked <= 1'b1;
        end
      end
    end
  end
  assign busy = state != S_IDLE;
  assign err_sat = &err_cnt;
endmodule

// File: tb/tb_prbs_bert_ctrl.sv
// tb_prbs_bert_ctrl: directed and randomized checks of prbs_bert_ctrl against a recurrence-based PRBS model
module tb_prbs_bert_ctrl;
  localparam logic [31:0] SEED_TB = 32'h0000_0001;
  localparam int DRAIN_TB = 8;
  localparam int LOCK_TB = 16;
  logic clk = 1'b0;
  logic rst_n, start, stop, inject, rx_bit, rx_valid, rx_bit4;
  logic [1:0] poly_sel;
  logic [15:0] burst_len;
  logic tx_bit, tx_valid, busy, done, locked, err_sat;
  logic [15:0] err_cnt;
  logic tx_bit4, tx_valid4, busy4, done4, locked4, err_sat4;
  logic [3:0] err_cnt4;
  int n_cmp = 0, n_err = 0;
  bit txq[$], rq[$], rq4[$], exp_q[$];
  int ntxv, last_tx, done_cyc, ndone, lock_at, lost_lock, lock4_seen, cyc, nrx, flip_at;
  bit loop;
  logic [2:0] vd, bd, bd4;
  always #5 clk = ~clk;
  prbs_bert_ctrl #(.SEED(SEED_TB), .ERR_W(16), .LOCK_RUN(LOCK_TB), .DRAIN_CYC(DRAIN_TB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .poly_sel(poly_sel), .burst_len(burst_len),
    .inject(inject), .tx_bit(tx_bit), .tx_valid(tx_valid), .rx_bit(rx_bit), .rx_valid(rx_valid),
    .busy(busy), .done(done), .locked(locked), .err_cnt(err_cnt), .err_sat(err_sat));
  prbs_bert_ctrl #(.SEED(SEED_TB), .ERR_W(4), .LOCK_RUN(LOCK_TB), .DRAIN_CYC(DRAIN_TB)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .poly_sel(poly_sel), .burst_len(burst_len),
    .inject(inject), .tx_bit(tx_bit4), .tx_valid(tx_valid4), .rx_bit(rx_bit4), .rx_valid(rx_valid),
    .busy(busy4), .done(done4), .locked(locked4), .err_cnt(err_cnt4), .err_sat(err_sat4));
  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  // Output stream of an LFSR seeded with SEED: b[n] = b[n-order] ^ b[n-tap], seed bits as prior history.
  function automatic void model_stream(input int p, input int n);
    int a, b;
    bit arr[$];
    logic [30:0] s;
    a = p == 0 ? 7 : p == 1 ? 15 : 31;
    b = p == 0 ? 6 : p == 1 ? 14 : 28;
    s = SEED_TB[30:0] & ((31'd1 << a) - 31'd1);
    if (s == 31'd0) s = 31'd1;
    exp_q.delete();
    for (int i = 0; i < a; i++) arr.push_back(s[a-1-i]);
    for (int j = a; j < a + n; j++) begin
      arr.push_back(arr[j-a] ^ arr[j-b]);
      exp_q.push_back(arr[j]);
    end
  endfunction
  function automatic int stream_diff(input int p);
    int d = 0;
    model_stream(p, txq.size());
    for (int i = 0; i < txq.size(); i++) if (txq[i] != exp_q[i]) d++;
    return d;
  endfunction
  function automatic bit rqb(input bit inv, input int i);
    return inv ? rq4[i] : rq[i];
  endfunction
  function automatic int model_err(input bit inv, input int p, input int ew, output bit lk);
    int a, b, run, miss, err, n;
    a = p == 0 ? 7 : p == 1 ? 15 : 31;
    b = p == 0 ? 6 : p == 1 ? 14 : 28;
    run = 0; miss = 0; err = 0; lk = 0;
    n = inv ? rq4.size() : rq.size();
    for (int i = a; i < n; i++) begin
      if (rqb(inv, i) ^ rqb(inv, i - a) ^ rqb(inv, i - b)) begin
        if (err < (1 << ew) - 1) err++;
        run = 0; miss++;
        if (miss >= 4) lk = 0;
      end else begin
        miss = 0; run++;
        if (run >= LOCK_TB) lk = 1;
      end
    end
    return err;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rx_valid) begin
      nrx++;
      rq.push_back(rx_bit);
      rq4.push_back(rx_bit4);
    end
    if (tx_valid) begin
      txq.push_back(tx_bit);
      ntxv++;
      last_tx = cyc;
    end
    if (done) begin
      ndone++;
      done_cyc = cyc;
    end
    if (locked && lock_at < 0) lock_at = nrx;
    if (lock_at >= 0 && !locked) lost_lock++;
    if (locked4) lock4_seen = 1;
    rx_valid = loop & vd[2];
    rx_bit = bd[2] ^ (rx_valid && nrx == flip_at);
    rx_bit4 = ~bd4[2];
    vd = {vd[1:0], tx_valid};
    bd = {bd[1:0], tx_bit};
    bd4 = {bd4[1:0], tx_bit4};
  endtask
  task automatic begin_run(input logic [1:0] p, input logic [15:0] l, input bit lp, input int flip);
    txq.delete(); rq.delete(); rq4.delete();
    ntxv = 0; ndone = 0; lock_at = -1; lost_lock = 0; lock4_seen = 0; nrx = 0; done_cyc = -1; last_tx = -1;
    loop = lp; flip_at = flip; vd = '0; bd = '0; bd4 = '0; rx_valid = 1'b0;
    poly_sel = p; burst_len = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic run(input logic [1:0] p, input logic [15:0] l, input bit lp, input int stop_at, input int flip);
    begin_run(p, l, lp, flip);
    for (int i = 0; i < 3000 && ndone == 0; i++) begin
      if (i == stop_at) stop = 1'b1;
      tick();
      stop = 1'b0;
    end
    for (int i = 0; i < 3; i++) tick();
  endtask
  initial begin
    int e, d;
    bit lk;
    logic [7:0] v;
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; poly_sel = '0; burst_len = '0; inject = 1'b0;
    rx_bit = 1'b0; rx_valid = 1'b0; rx_bit4 = 1'b0; loop = 0; vd = '0; bd = '0; bd4 = '0;
    cyc = 0; nrx = 0; lock_at = -1; flip_at = -1;
    tick(); tick();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_bit", tx_bit, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_locked", locked, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_err_sat", err_sat, 0);
    rst_n = 1'b0;
    tick();
    stop = 1'b1; tick(); stop = 1'b0; tick();
    check("stop_idle_busy", busy, 0);
    // PRBS7 short burst, no loopback
    run(2'd0, 16'd8, 0, -1, -1);
    v = '0;
    foreach (txq[i]) v = {v[6:0], txq[i]};
    check("t1_stream", v, 8'b0000_0110);
    check("t1_nvalid", ntxv, 8);
    check("t1_done_delay", done_cyc - last_tx, DRAIN_TB + 1);
    check("t1_done_pulses", ndone, 1);
    check("t1_err_cnt", err_cnt, 0);
    check("t1_locked", locked, 0);
    check("t1_busy", busy, 0);
    // PRBS7 254 bits looped back through 3 cycles of delay; dut4 sees the inverted loop
    run(2'd0, 16'd254, 1, -1, -1);
    check("t2_stream", stream_diff(0), 0);
    d = txq.size() < 254 ? 999 : 0;
    for (int i = 0; i < 127 && txq.size() >= 254; i++) if (txq[i] != txq[i+127]) d++;
    check("t2_period", d, 0);
    check("t2_lock_at", lock_at, 7 + LOCK_TB);
    check("t2_err_cnt", err_cnt, 0);
    e = model_err(0, 0, 16, lk);
    check("t2_err_model", err_cnt, e);
    check("t2_locked_hold", locked, lk);
    e = model_err(1, 0, 4, lk);
    check("t2_inv_err_model", err_cnt4, e);
    check("t2_inv_err_cnt", err_cnt4, 15);
    check("t2_inv_err_sat", err_sat4, 1);
    check("t2_inv_never_locked", lock4_seen, 0);
    // PRBS31 continuous, stopped after 1000 cycles
    run(2'd2, 16'd0, 1, 1000, -1);
    check("t3_stream", stream_diff(2), 0);
    check("t3_ntx_min", ntxv >= 990, 1);
    check("t3_err_cnt", err_cnt, 0);
    check("t3_locked", locked, 1);
    check("t3_done_pulses", ndone, 1);
    check("t3_busy", busy, 0);
    // PRBS15, one received bit inverted after lock; flip position randomized past the lock point
    run(2'd1, 16'd400, 1, -1, 60 + int'($urandom_range(0, 200)));
    check("t4_lock_at", lock_at, 15 + LOCK_TB);
    check("t4_err_cnt", err_cnt, 3);
    e = model_err(0, 1, 16, lk);
    check("t4_err_model", err_cnt, e);
    check("t4_lost_lock", lost_lock, 0);
    check("t4_locked", locked, 1);
    check("t4_stream", stream_diff(1), 0);
    // start while busy is ignored, then reset mid-run
    begin_run(2'd0, 16'd200, 1, -1);
    for (int i = 0; i < 60; i++) begin
      if (i == 10) begin
        start = 1'b1;
        poly_sel = 2'd2;
      end
      tick();
      start = 1'b0;
    end
    check("t6_busy_after_start", busy, 1);
    check("t6_stream", stream_diff(0), 0);
    check("t6_locked_pre", locked, 1);
    check("t6_inv_err_pre", err_cnt4, 15);
    loop = 0;
    rst_n = 1'b1;
    tick();
    check("t6_rst_tx_valid", tx_valid, 0);
    check("t6_rst_tx_bit", tx_bit, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_locked", locked, 0);
    check("t6_rst_err_cnt", err_cnt, 0);
    check("t6_rst_inv_err_cnt", err_cnt4, 0);
    check("t6_rst_inv_err_sat", err_sat4, 0);
    rst_n = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) tick();
    check("t6_no_done_after_rst", ndone, 0);
    run(2'd0, 16'd8, 0, -1, -1);
    v = '0;
    foreach (txq[i]) v = {v[6:0], txq[i]};
    check("t6_fresh_stream", v, 8'b0000_0110);
    check("t6_fresh_nvalid", ntxv, 8);
    check("t6_fresh_done", ndone, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
